// File: rtl/apb4_plic_claimer.sv
// apb4_plic_claimer: APB4 initiator on the interrupt-target side of the PLIC
// claim/complete protocol. It claims an ID by reading CLAIMCOMP, hands the ID
// to a dispatcher, and writes the same ID back once the dispatcher is done.
//
// Handshake: the dispatcher channel is strict valid/ready. A transfer happens on
// a rising clock edge where irq_valid_o && irq_ready_i. While irq_valid_o is high,
// irq_id_o is held stable, and irq_valid_o never drops until that transfer happens.
// irq_done_i is a single-cycle pulse. It is honoured only once the ID has been accepted.
module apb4_plic_claimer #(
  parameter int              ADDR_WIDTH  = 32,
  parameter int              DATA_WIDTH  = 32,
  parameter int              ID_WIDTH    = 5,
  parameter logic [31:0]     CLAIM_ADDR  = 32'h1C,
  parameter int              TIMEOUT_CYC = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    ext_irq_i,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i,
  output logic                    irq_valid_o,
  output logic [ID_WIDTH-1:0]     irq_id_o,
  input  logic                    irq_ready_i,
  input  logic                    irq_done_i,
  output logic                    busy_o,
  output logic                    err_o,
  output logic [7:0]              spurious_o,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    C_SETUP  = 3'd1,
    C_ACCESS = 3'd2,
    DISPATCH = 3'd3,
    SERVICE  = 3'd4,
    W_SETUP  = 3'd5,
    W_ACCESS = 3'd6
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ID_WIDTH-1:0] id_q;
  logic [7:0]          tmo_cnt;
  logic                err_q;
  logic [7:0]          spur_q;

  logic                in_setup;
  logic                in_access;
  logic                timed_out;
  logic                claim_ok;
  logic                claim_zero;
  logic [ID_WIDTH-1:0] rd_id;
  logic                unused_rdata;

  assign rd_id        = prdata_i[ID_WIDTH-1:0];
  assign unused_rdata = ^prdata_i[DATA_WIDTH-1:ID_WIDTH];
  assign in_setup     = (state == C_SETUP) || (state == W_SETUP);
  assign in_access    = (state == C_ACCESS) || (state == W_ACCESS);
  // The abort fires in the cycle that would be the TIMEOUT_CYC-th stalled ACCESS cycle.
  assign timed_out    = in_access && !pready_i && (tmo_cnt == 8'(TIMEOUT_CYC - 1));
  assign claim_ok     = (state == C_ACCESS) && pready_i && !pslverr_i && (rd_id != '0);
  assign claim_zero   = (state == C_ACCESS) && pready_i && !pslverr_i && (rd_id == '0);

  // State register; async reset abandons any outstanding claim.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic for the claim / dispatch / complete sequence.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (ext_irq_i) state_nxt = C_SETUP;
      C_SETUP:  state_nxt = C_ACCESS;
      C_ACCESS: begin
        if (pready_i) state_nxt = claim_ok ? DISPATCH : IDLE;
        else if (timed_out) state_nxt = IDLE;
      end
      DISPATCH: if (irq_ready_i) state_nxt = SERVICE;
      SERVICE:  if (irq_done_i) state_nxt = W_SETUP;
      W_SETUP:  state_nxt = W_ACCESS;
      W_ACCESS: if (pready_i || timed_out) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Datapath registers: claimed ID, ACCESS timeout counter, sticky error, spurious count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      id_q    <= '0;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
      spur_q  <= '0;
    end else begin
      if (in_setup)                    tmo_cnt <= '0;
      else if (in_access && !pready_i) tmo_cnt <= tmo_cnt + 8'd1;
      if (claim_ok) id_q <= rd_id;
      if ((in_access && pready_i && pslverr_i) || timed_out) err_q <= 1'b1;
      if (claim_zero && (spur_q != 8'hFF)) spur_q <= spur_q + 8'd1;
    end
  end

  // Outputs decode only the state flops and held registers, so they stay
  // glitch-free and constant from SETUP through the end of ACCESS.
  always_comb begin
    psel_o      = in_setup || in_access;
    penable_o   = in_access;
    pwrite_o    = (state == W_SETUP) || (state == W_ACCESS);
    paddr_o     = psel_o ? ADDR_WIDTH'(CLAIM_ADDR) : '0;
    pwdata_o    = pwrite_o ? DATA_WIDTH'(id_q) : '0;
    pstrb_o     = pwrite_o ? '1 : '0;
    irq_valid_o = (state == DISPATCH);
    irq_id_o    = (state == DISPATCH) ? id_q : '0;
    busy_o      = (state != IDLE);
    err_o       = err_q;
    spurious_o  = spur_q;
    state_o     = state;
  end

endmodule

// File: tb/tb_apb4_plic_claimer.sv
// Bench for apb4_plic_claimer: behavioural APB target plus a transfer/ID scoreboard.
module tb_apb4_plic_claimer;

  localparam int TW = 65;  // {pwrite, paddr[31:0], pwdata[31:0]}
  localparam logic [31:0] CLAIM = 32'h1C;

  logic        clk;
  logic        rst_n;
  logic        ext_irq;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        irq_valid;
  logic [4:0]  irq_id;
  logic        irq_ready;
  logic        irq_done;
  logic        busy;
  logic        err;
  logic [7:0]  spurious;
  logic [2:0]  state;

  apb4_plic_claimer dut (
    .clk_i(clk), .rst_n_i(rst_n), .ext_irq_i(ext_irq),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .pready_i(pready), .prdata_i(prdata),
    .pslverr_i(pslverr), .irq_valid_o(irq_valid), .irq_id_o(irq_id),
    .irq_ready_i(irq_ready), .irq_done_i(irq_done), .busy_o(busy), .err_o(err),
    .spurious_o(spurious), .state_o(state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [TW-1:0] exp_q[$];
  logic [4:0]    exp_id_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- APB target model + monitor ----------------
  int          wait_cycles = 0;
  logic [31:0] rd_val = '0;
  logic        err_rd = 1'b0;
  logic        err_wr = 1'b0;
  int          acc_cnt = 0;
  logic        prev_psel = 1'b0;
  logic        cap_w;
  logic [31:0] cap_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      pready = 1'b0; pslverr = 1'b0; prdata = '0; acc_cnt = 0; prev_psel = 1'b0;
    end else begin
      if (psel && penable) begin
        if (acc_cnt >= wait_cycles) begin
          pready  = 1'b1;
          prdata  = pwrite ? 32'h0 : rd_val;
          pslverr = pwrite ? err_wr : err_rd;
        end else begin
          pready = 1'b0; pslverr = 1'b0;
        end
        acc_cnt++;
      end else begin
        pready = 1'b0; pslverr = 1'b0; acc_cnt = 0;
      end
      if (psel) begin
        check("penable_phase", penable, prev_psel);
        check("paddr", paddr, CLAIM);
        if (!prev_psel) begin
          cap_w = pwrite; cap_d = pwdata;
        end else begin
          check("ctl_stable", {pwrite, pwdata}, {cap_w, cap_d});
        end
      end
      if (psel && penable && pready) begin
        check("apb_expected", 32'(exp_q.size() > 0), 1);
        check("pstrb", pstrb, pwrite ? 4'hF : 4'h0);
        if (exp_q.size() > 0)
          check("apb_xfer", {pwrite, paddr, pwrite ? pwdata : 32'h0}, exp_q.pop_front());
      end
      if (irq_valid && irq_ready) begin
        check("id_expected", 32'(exp_id_q.size() > 0), 1);
        if (exp_id_q.size() > 0) check("irq_id", irq_id, exp_id_q.pop_front());
      end
      prev_psel = psel;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string tag);
    check({tag, "_psel"}, psel, 0);
    check({tag, "_penable"}, penable, 0);
    check({tag, "_pwrite"}, pwrite, 0);
    check({tag, "_paddr"}, paddr, 0);
    check({tag, "_pwdata"}, pwdata, 0);
    check({tag, "_pstrb"}, pstrb, 0);
    check({tag, "_valid"}, irq_valid, 0);
    check({tag, "_id"}, irq_id, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_spur"}, spurious, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ext_irq = 1'b0; irq_ready = 1'b0; irq_done = 1'b0;
    err_rd = 1'b0; err_wr = 1'b0; wait_cycles = 0;
    exp_q.delete(); exp_id_q.delete();
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_irq();
    @(posedge clk); #1 ext_irq = 1'b1;
    @(posedge clk); #1 ext_irq = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    check(tag, busy, 0);
  endtask

  // Full claim sequence; optionally stalls the accept, sends stray done pulses,
  // or resets the DUT once the ID has been accepted.
  task automatic claim(input logic [4:0] id, input int waits, input int rdy_delay,
                       input bit early_done, input bit done_at_accept, input bit rst_in_service);
    int n = 0;
    rd_val = 32'(id); wait_cycles = waits;
    exp_q.push_back({1'b0, CLAIM, 32'h0});
    exp_id_q.push_back(id);
    pulse_irq();
    while (!irq_valid && n < 600) begin
      @(posedge clk); #1; n++;
    end
    check("valid_seen", irq_valid, 1);
    for (int i = 0; i < rdy_delay; i++) begin
      check("valid_hold", irq_valid, 1);
      check("id_hold", irq_id, id);
      irq_done = early_done && (i == 2);
      @(posedge clk); #1;
      irq_done = 1'b0;
    end
    irq_ready = 1'b1; irq_done = done_at_accept;
    @(posedge clk); #1;
    irq_ready = 1'b0; irq_done = 1'b0;
    if (rst_in_service) begin
      check("in_service", state, 3'd4);
      rst_n = 1'b0;
      #1;
      check_zero("rst_service");
      exp_q.delete(); exp_id_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      return;
    end
    repeat (3) begin
      check("service_busy", busy, 1);
      check("service_novalid", irq_valid, 0);
      @(posedge clk); #1;
    end
    exp_q.push_back({1'b1, CLAIM, 32'(id)});
    irq_done = 1'b1;
    @(posedge clk); #1;
    irq_done = 1'b0;
    wait_idle("claim_idle");
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    do_reset();

    // Basic claim / complete, then a claim with a stalled read.
    claim(5'd3, 0, 0, 1'b0, 1'b0, 1'b0);
    check("basic_noerr", err, 0);
    claim(5'd5, 3, 0, 1'b0, 1'b0, 1'b0);

    // Spurious claims: ID 0 must not dispatch or write back; count saturates.
    irq_ready = 1'b1;
    rd_val = 32'h0; wait_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back({1'b0, CLAIM, 32'h0});
      pulse_irq();
      wait_idle("spur_idle");
      if (i == 2) check("spur_three", spurious, 3);
    end
    check("spur_sat", spurious, 255);
    irq_ready = 1'b0;

    // Timeout on the claim read.
    wait_cycles = 100000;
    pulse_irq();
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (!psel) break;
      n++;
    end
    check("tmo_psel_cycles", n, 256);
    #1;
    check("tmo_err", err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_state", state, 0);

    // Slave error on the claim read: no dispatch.
    do_reset();
    irq_ready = 1'b1; err_rd = 1'b1; rd_val = 32'h4;
    exp_q.push_back({1'b0, CLAIM, 32'h0});
    pulse_irq();
    wait_idle("rderr_idle");
    repeat (2) @(posedge clk);
    #1;
    check("rderr_err", err, 1);
    check("rderr_novalid", irq_valid, 0);
    irq_ready = 1'b0; err_rd = 1'b0;

    // Slave error on the completion write.
    do_reset();
    err_wr = 1'b1;
    claim(5'd7, 1, 2, 1'b0, 1'b0, 1'b0);
    check("wrerr_err", err, 1);
    check("wrerr_state", state, 0);
    err_wr = 1'b0;

    // Stalled accept with stray done pulses in DISPATCH and at the accept.
    do_reset();
    claim(5'd11, 10, 0, 1'b1, 1'b1, 1'b0);
    claim(5'd31, 0, 10, 1'b1, 1'b1, 1'b0);

    // Reset during C_ACCESS, then a fresh claim.
    rd_val = 32'h9; wait_cycles = 5;
    pulse_irq();
    @(negedge clk); @(negedge clk);
    check("in_caccess", {psel, penable}, 2'b11);
    rst_n = 1'b0;
    #1;
    check_zero("rst_caccess");
    exp_q.delete(); exp_id_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    claim(5'd9, 0, 0, 1'b0, 1'b0, 1'b0);

    // Reset during SERVICE, then a fresh claim.
    claim(5'd6, 0, 1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", busy, 0);
    claim(5'd12, 2, 1, 1'b0, 1'b0, 1'b0);

    check("exp_q_empty", exp_q.size(), 0);
    check("exp_id_q_empty", exp_id_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
